// File: rtl/i2c_target_port_if.sv
// i2c_target_port_if
// Byte-level handshake between the I2C target port and the local client.
//   rx_data  [7:0]  target -> client  last received write byte
//   rx_valid        target -> client  1-cycle pulse, rx_data updated
//   rx_ready        client -> target  client can accept a write byte
//   tx_req          target -> client  1-cycle pulse, a read byte is needed
//   tx_data  [7:0]  client -> target  read byte
//   tx_valid        client -> target  tx_data is valid
// Modports: slave = the target port itself, master = the client side.
interface i2c_target_port_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport slave (
    output rx_data, rx_valid, tx_req,
    input  rx_ready, tx_data, tx_valid
  );

  modport master (
    input  rx_data, rx_valid, tx_req,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/i2c_target_port.sv
// i2c_target_port
// I2C target (responder). Oversamples SCL/SDA, filters glitches, detects
// START/STOP, matches a 7-bit address, receives write bytes, serves read bytes
// and stretches SCL while the client has not yet supplied read data.
// The bus is driven open-drain only: *_oe = 1 pulls the line low.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   scl_i, sda_i    raw pad levels
//   scl_oe, sda_oe  pull-low enables (clock stretch / ACK or data 0)
//   busy            high from START to STOP
//   hs              byte handshake (rx_*, tx_*), see i2c_target_port_if
module i2c_target_port #(
  parameter logic [6:0]  TARGET_ADDR   = 7'h50,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned GLITCH_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_oe,
  output logic             sda_oe,
  output logic             busy,
  i2c_target_port_if.slave hs
);

  localparam int unsigned CW = $clog2(GLITCH_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, TX_LOAD, TX_BYTE, TX_ACK, WAIT_STOP
  } state_t;

  // ---------------- input conditioning: line 0 = SCL, line 1 = SDA ----------------
  logic [1:0] raw_in, filt, filt_prev;
  assign raw_in = {sda_i, scl_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   filt_q, prev_q;

    // The filtered level only moves after GLITCH_CYCLES consecutive
    // synchronised samples disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '1;
        cnt_q  <= '0;
        filt_q <= 1'b1;
        prev_q <= 1'b1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[gi]};
        prev_q <= filt_q;
        if (sync_q[SYNC_STAGES-1] == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(GLITCH_CYCLES - 1)) begin
          filt_q <= sync_q[SYNC_STAGES-1];
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign filt[gi]      = filt_q;
    assign filt_prev[gi] = prev_q;
  end

  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt[0];
  assign sda_f     = filt[1];
  assign scl_p     = filt_prev[0];
  assign sda_p     = filt_prev[1];
  assign scl_rise  = scl_f & ~scl_p;
  assign scl_fall  = ~scl_f & scl_p;
  assign start_det = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;

  // ---------------- protocol FSM ----------------
  state_t     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       ack_on_q, ack_on_d;   // ACK slot: 0 = waiting to drive, 1 = driving
  logic       have_q, have_d;       // TX_LOAD: read byte already latched
  logic       fell_q, fell_d;       // TX_LOAD: SCL is already in its low phase
  logic       sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d, busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;

  logic [7:0] byte_in, tx_byte;
  logic       tx_low;
  assign byte_in = {shreg_q[6:0], sda_f};
  assign tx_byte = have_q ? shreg_q : hs.tx_data;
  assign tx_low  = fell_q | scl_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      ack_on_q   <= 1'b0;
      have_q     <= 1'b0;
      fell_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      ack_on_q   <= ack_on_d;
      have_q     <= have_d;
      fell_q     <= fell_d;
      sda_oe_q   <= sda_oe_d;
      scl_oe_q   <= scl_oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    ack_on_d   = ack_on_q;
    have_d     = have_q;
    fell_d     = fell_q;
    sda_oe_d   = sda_oe_q;
    scl_oe_d   = scl_oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;

    // Bus conditions win over any SCL edge seen in the same cycle.
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shreg_d  = byte_in;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              ack_on_d = 1'b0;
              state_d  = (byte_in[7:1] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
            end
          end
        end
        // First falling edge starts the ACK, the next one (end of 9th clock) ends it.
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ack_on_d = 1'b0;
              if (state_q == WR_ACK || !shreg_q[0]) begin
                state_d = WR_BYTE;
              end else begin
                state_d  = TX_LOAD;
                tx_req_d = 1'b1;
                have_d   = 1'b0;
                fell_d   = 1'b1;   // entered right on the falling edge
              end
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shreg_d  = byte_in;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (hs.rx_ready) begin
                rx_data_d  = byte_in;
                rx_valid_d = 1'b1;
                ack_on_d   = 1'b0;
                state_d    = WR_ACK;
              end else begin
                state_d = WAIT_STOP;   // SDA stays released: NACK
              end
            end
          end
        end
        TX_LOAD: begin
          if (scl_fall) fell_d = 1'b1;
          if (!have_q && hs.tx_valid) begin
            shreg_d = hs.tx_data;
            have_d  = 1'b1;
          end
          if (tx_low && (have_q || hs.tx_valid)) begin
            // Put bit 7 on the bus now; scl_oe is dropped in TX_BYTE one cycle later.
            sda_oe_d = ~tx_byte[7];
            shreg_d  = {tx_byte[6:0], 1'b0};
            bitcnt_d = '0;
            state_d  = TX_BYTE;
          end else if (tx_low) begin
            scl_oe_d = 1'b1;
          end
        end
        TX_BYTE: begin
          scl_oe_d = 1'b0;
          if (scl_fall) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = TX_ACK;
            end else begin
              sda_oe_d = ~shreg_q[7];
              shreg_d  = {shreg_q[6:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              state_d  = TX_LOAD;
              tx_req_d = 1'b1;
              have_d   = 1'b0;
              fell_d   = 1'b0;   // SCL still high; stretch starts at its fall
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        IDLE, WAIT_STOP: begin
          sda_oe_d = 1'b0;
          scl_oe_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign scl_oe      = scl_oe_q;
  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign hs.rx_data  = rx_data_q;
  assign hs.rx_valid = rx_valid_q;
  assign hs.tx_req   = tx_req_q;

endmodule

// File: tb/tb_i2c_target_port.sv
// tb_i2c_target_port
// Bus-level controller model driving open-drain SCL/SDA, a read-data responder
// and scoreboard monitors for rx bytes and bus read bytes.
module tb_i2c_target_port;
  localparam int HALF = 20;   // SCL half period in clk cycles
  localparam int QTR  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_drv = 1'b0;
  logic sda_drv = 1'b0;
  logic scl_i, sda_i, scl_oe, sda_oe, busy;

  i2c_target_port_if u_if();

  // Open-drain wired-AND of controller and target.
  assign scl_i = ~(scl_drv | scl_oe);
  assign sda_i = ~(sda_drv | sda_oe);

  i2c_target_port #(
    .TARGET_ADDR  (7'h50),
    .SYNC_STAGES  (2),
    .GLITCH_CYCLES(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl_i (scl_i),
    .sda_i (sda_i),
    .scl_oe(scl_oe),
    .sda_oe(sda_oe),
    .busy  (busy),
    .hs    (u_if.slave)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] tx_src[$];
  int         tx_dly[$];

  int   rx_pulses = 0;
  int   tx_req_cnt = 0;
  int   scl_oe_cyc = 0;
  int   sda_oe_cyc = 0;
  int   busy_cyc = 0;
  int   busy_low_cyc = 0;
  logic track_busy = 1'b0;
  logic [7:0] rd_val;
  event rd_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int t;
    t = 0;
    while (scl_i !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (scl_i !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL scl_release_timeout: scl low for %0d clks, required high", t);
    end
  endtask

  // Enters and leaves with SCL low, a quarter period into the low phase.
  task automatic clock_bit(input logic b_out, output logic b_in);
    sda_drv = ~b_out;
    tick(QTR);
    scl_drv = 1'b0;
    wait_scl_high();
    tick(HALF / 2);
    b_in = sda_i;
    tick(HALF / 2);
    scl_drv = 1'b1;
    tick(QTR);
  endtask

  task automatic i2c_start();
    if (scl_drv) begin
      sda_drv = 1'b0;
      tick(QTR);
      scl_drv = 1'b0;
      wait_scl_high();
    end
    tick(HALF / 2);
    sda_drv = 1'b1;
    tick(HALF / 2);
    scl_drv = 1'b1;
    tick(QTR);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b1;
    tick(QTR);
    scl_drv = 1'b0;
    wait_scl_high();
    tick(HALF / 2);
    sda_drv = 1'b0;
    tick(HALF);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~ack, s);
    rd_val = b;
    ->rd_done;
  endtask

  // Output monitor: rx scoreboard plus activity counters.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (u_if.rx_valid) begin
          rx_pulses++;
          if (exp_rx.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected: got rx_valid with rx_data 0x%0h, required none", u_if.rx_data);
          end else begin
            check("rx_data", {24'h0, u_if.rx_data}, {24'h0, exp_rx.pop_front()});
          end
        end
        if (u_if.tx_req) tx_req_cnt++;
        if (scl_oe) scl_oe_cyc++;
        if (sda_oe) sda_oe_cyc++;
        if (busy) busy_cyc++;
        if (track_busy && !busy) busy_low_cyc++;
      end
    end
  end

  // Bus read-byte scoreboard.
  initial begin
    forever begin
      @(rd_done);
      if (exp_rd.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got bus byte 0x%0h, required none", rd_val);
      end else begin
        check("rd_byte", {24'h0, rd_val}, {24'h0, exp_rd.pop_front()});
      end
    end
  end

  // Read-data responder: answers each tx_req after the queued delay.
  initial begin
    int d;
    logic [7:0] b;
    u_if.tx_valid = 1'b0;
    u_if.tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && u_if.tx_req) begin
        if (tx_src.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_req_unexpected: got tx_req with no read data queued, required none");
        end else begin
          d = tx_dly.pop_front();
          b = tx_src.pop_front();
          repeat (d) @(negedge clk);
          u_if.tx_data  = b;
          u_if.tx_valid = 1'b1;
          @(negedge clk);
          u_if.tx_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #1600000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, s;
    logic [7:0] rb;
    u_if.rx_ready = 1'b1;
    rst_n = 1'b0;
    tick(5);
    check("reset_outputs", {19'h0, scl_oe, sda_oe, busy, u_if.rx_valid, u_if.tx_req, u_if.rx_data}, 32'h0);
    rst_n = 1'b1;
    tick(10);

    // T1: write 0x3C to 0x50
    exp_rx.push_back(8'h3C);
    i2c_start();
    write_byte(8'hA0, ack);
    check("t1_addr_ack", {31'h0, ack}, 32'h1);
    write_byte(8'h3C, ack);
    check("t1_data_ack", {31'h0, ack}, 32'h1);
    check("t1_busy_mid", {31'h0, busy}, 32'h1);
    i2c_stop();
    check("t1_busy_after_stop", {31'h0, busy}, 32'h0);
    check("t1_rx_pulses", rx_pulses, 1);

    // T2: address 0x51 is not ours
    sda_oe_cyc = 0;
    i2c_start();
    write_byte(8'hA2, ack);
    check("t2_addr_nack", {31'h0, ack}, 32'h0);
    write_byte(8'hFF, ack);
    check("t2_data_nack", {31'h0, ack}, 32'h0);
    i2c_stop();
    check("t2_sda_oe_cycles", sda_oe_cyc, 0);
    check("t2_busy_after_stop", {31'h0, busy}, 32'h0);

    // T3: read 0x96 (late data, stretched) then 0x5A
    tx_req_cnt = 0;
    scl_oe_cyc = 0;
    tx_src.push_back(8'h96); tx_dly.push_back(40);
    tx_src.push_back(8'h5A); tx_dly.push_back(2);
    exp_rd.push_back(8'h96);
    exp_rd.push_back(8'h5A);
    i2c_start();
    write_byte(8'hA1, ack);
    check("t3_addr_ack", {31'h0, ack}, 32'h1);
    read_byte(1'b1, rb);
    read_byte(1'b0, rb);
    i2c_stop();
    check("t3_tx_req_pulses", tx_req_cnt, 2);
    check("t3_stretch_about_40", {31'h0, (scl_oe_cyc >= 36 && scl_oe_cyc <= 46)}, 32'h1);
    check("t3_busy_after_stop", {31'h0, busy}, 32'h0);

    // T4: write 0x11, repeated START, read 0x77
    exp_rx.push_back(8'h11);
    tx_src.push_back(8'h77); tx_dly.push_back(5);
    exp_rd.push_back(8'h77);
    i2c_start();
    write_byte(8'hA0, ack);
    check("t4_addr_ack", {31'h0, ack}, 32'h1);
    track_busy = 1'b1;
    busy_low_cyc = 0;
    write_byte(8'h11, ack);
    check("t4_data_ack", {31'h0, ack}, 32'h1);
    i2c_start();
    write_byte(8'hA1, ack);
    check("t4_rd_addr_ack", {31'h0, ack}, 32'h1);
    read_byte(1'b0, rb);
    track_busy = 1'b0;
    check("t4_busy_gap_cycles", busy_low_cyc, 0);
    check("t4_rx_data_held", {24'h0, u_if.rx_data}, 32'h11);
    i2c_stop();

    // T5: 2-clk SDA glitch while SCL high
    busy_cyc = 0;
    sda_drv = 1'b1;
    tick(2);
    sda_drv = 1'b0;
    tick(30);
    check("t5_glitch_busy_cycles", busy_cyc, 0);

    // T6: second write byte refused by the sink
    exp_rx.push_back(8'h11);
    i2c_start();
    write_byte(8'hA0, ack);
    check("t6_addr_ack", {31'h0, ack}, 32'h1);
    write_byte(8'h11, ack);
    check("t6_data1_ack", {31'h0, ack}, 32'h1);
    u_if.rx_ready = 1'b0;
    write_byte(8'h22, ack);
    check("t6_data2_nack", {31'h0, ack}, 32'h0);
    u_if.rx_ready = 1'b1;
    i2c_stop();
    check("t6_rx_pulses_total", rx_pulses, 3);

    // T7: asynchronous reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      rb = 8'hA0;
      clock_bit(rb[i], s);
    end
    check("t7_ack_driven", {31'h0, sda_oe}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t7_reset_outputs", {19'h0, scl_oe, sda_oe, busy, u_if.rx_valid, u_if.tx_req, u_if.rx_data}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    clock_bit(1'b1, s);
    check("t7_ack_slot_released", {31'h0, s}, 32'h1);
    write_byte(8'h3C, ack);
    check("t7_ignored_nack", {31'h0, ack}, 32'h0);
    check("t7_busy_ignored", {31'h0, busy}, 32'h0);
    i2c_stop();

    check("end_rx_queue_empty", exp_rx.size(), 0);
    check("end_rd_queue_empty", exp_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
